// File: rtl/sprite_renderer.sv
// sprite_renderer: erases the previous sprite, then draws the new one, one pixel write per clock.
// Optional horizontal flip (mirror_in) is enabled by defining SPRITE_RENDERER_MIRROR_EN.
module sprite_renderer #(
  parameter int SPRITE_W = 7,
  parameter int SPRITE_H = 7,
  parameter int NUM_STYLES = 2,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0,
  parameter logic [NUM_STYLES*SPRITE_W*SPRITE_H-1:0] SPRITE_MAP = '0,
  localparam int S_W = NUM_STYLES > 1 ? $clog2(NUM_STYLES) : 1,
  localparam int XS = X_W + 1,
  localparam int YS = Y_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [S_W-1:0]      style_in,
  input  logic [COLOUR_W-1:0] colour_in,
`ifdef SPRITE_RENDERER_MIRROR_EN
  input  logic                mirror_in,
`endif
  output logic                busy,
  output logic                done,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
  state_t state, state_n;
  logic [3:0] row, col, bcol;
  logic [X_W-1:0] cur_x, prev_x;
  logic [Y_W-1:0] cur_y, prev_y;
  logic [S_W-1:0] cur_style, prev_style, sty;
  logic [COLOUR_W-1:0] cur_colour;
  logic cur_mirror, prev_mirror, mir, mirror_lat, prev_valid;
  logic scan, erasing, last_col, last, bit_on;
  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic [31:0] idx;
`ifdef SPRITE_RENDERER_MIRROR_EN
  assign mirror_lat = mirror_in;
`else
  assign mirror_lat = 1'b0;
`endif
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign erasing = state == ERASE;
  assign scan = erasing || state == DRAW;
  assign last_col = col == 4'(SPRITE_W - 1);
  assign last = last_col && row == 4'(SPRITE_H - 1);
  // erase reads the previous request's bitmap, draw reads the current one
  assign sty = erasing ? prev_style : cur_style;
  assign mir = erasing ? prev_mirror : cur_mirror;
  assign bcol = mir ? 4'(SPRITE_W - 1) - col : col;
  assign idx = (32'(sty) * SPRITE_H + 32'(row)) * SPRITE_W + 32'(bcol);
  assign bit_on = 1'(SPRITE_MAP >> idx);
  assign px = (erasing ? {1'b0, prev_x} : {1'b0, cur_x}) + XS'(col);
  assign py = (erasing ? {1'b0, prev_y} : {1'b0, cur_y}) + YS'(row);
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = start ? (prev_valid ? ERASE : DRAW) : IDLE;
    else if (scan && last) state_n = erasing ? DRAW : DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
      plot <= 1'b0;
      x <= '0;
      y <= '0;
      colour <= '0;
      prev_valid <= 1'b0;
      cur_x <= '0;
      cur_y <= '0;
      cur_style <= '0;
      cur_colour <= '0;
      cur_mirror <= 1'b0;
      prev_x <= '0;
      prev_y <= '0;
      prev_style <= '0;
      prev_mirror <= 1'b0;
    end else begin
      col <= scan && !last_col ? col + 4'd1 : '0;
      row <= !scan ? '0 : last_col ? (last ? '0 : row + 4'd1) : row;
      // sums are one bit wider than the screen coordinates so off-screen pixels clip instead of wrapping
      plot <= scan && bit_on && px < XS'(SCREEN_W) && py < YS'(SCREEN_H);
      x <= px[X_W-1:0];
      y <= py[Y_W-1:0];
      colour <= erasing ? BG_COLOUR : cur_colour;
      if (state == IDLE && start) begin
        cur_x <= x_in;
        cur_y <= y_in;
        cur_style <= 32'(style_in) >= NUM_STYLES ? '0 : style_in;
        cur_colour <= colour_in;
        cur_mirror <= mirror_lat;
      end
      if (done) begin
        prev_x <= cur_x;
        prev_y <= cur_y;
        prev_style <= cur_style;
        prev_mirror <= cur_mirror;
        prev_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: directed and randomized draw requests checked against a pixel-list model.
module tb_sprite_renderer;
  localparam int W = 7, H = 7, NS = 3;
  localparam logic [NS*W*H-1:0] MAP = {49'h1_3579_BDF0_2468, 49'h8, {49{1'b1}}};
  logic clk, reset, start, busy, done, plot;
  logic [7:0] x_in, x;
  logic [6:0] y_in, y;
  logic [1:0] style_in;
  logic [2:0] colour_in, colour;
`ifdef SPRITE_RENDERER_MIRROR_EN
  logic mirror_in;
`endif
  int errs = 0, checks = 0;
  int pv = 0, pxo = 0, pyo = 0, pst = 0, pmr = 0;
  int exp_q[$];

  sprite_renderer #(.SPRITE_W(W), .SPRITE_H(H), .NUM_STYLES(NS), .SPRITE_MAP(MAP)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .style_in(style_in), .colour_in(colour_in),
`ifdef SPRITE_RENDERER_MIRROR_EN
    .mirror_in(mirror_in),
`endif
    .busy(busy), .done(done), .plot(plot), .x(x), .y(y), .colour(colour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_pixels(int ox, int oy, int s, int m, int c);
    int sty;
    sty = s >= NS ? 0 : s;
    for (int r = 0; r < H; r++)
      for (int cc = 0; cc < W; cc++) begin
        int bc;
        bc = m != 0 ? W - 1 - cc : cc;
        if (1'(MAP >> ((sty * H + r) * W + bc)) && ox + cc < 160 && oy + r < 120)
          exp_q.push_back(((ox + cc) << 10) | ((oy + r) << 3) | c);
      end
  endtask

  task automatic do_req(int nx, int ny, int ns, int nc, int nm, bit hold);
    int n, dn, exp_busy;
    logic [17:0] got_q[$];
`ifndef SPRITE_RENDERER_MIRROR_EN
    nm = 0;
`endif
    exp_q.delete();
    if (pv != 0) add_pixels(pxo, pyo, pst, pmr, 0);
    add_pixels(nx, ny, ns, nm, nc);
    exp_busy = pv != 0 ? 2 * W * H + 1 : W * H + 1;
    x_in = 8'(nx);
    y_in = 7'(ny);
    style_in = 2'(ns);
    colour_in = 3'(nc);
`ifdef SPRITE_RENDERER_MIRROR_EN
    mirror_in = nm[0];
`endif
    start = 1'b1;
    n = 0;
    dn = 0;
    @(negedge clk);
    if (!hold) start = 1'b0;
    while (busy && n < 400) begin
      n++;
      if (plot) got_q.push_back({x, y, colour});
      if (done) dn++;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_len", n, exp_busy);
    check("done_pulses", dn, 1);
    check("idle_plot", int'(plot), 0);
    check("plot_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("pixel_xyc", int'(got_q[i]), exp_q[i]);
    pv = 1;
    pxo = nx;
    pyo = ny;
    pst = ns >= NS ? 0 : ns;
    pmr = nm;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_plot"}, int'(plot), 0);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_colour"}, int'(colour), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    x_in = '0;
    y_in = '0;
    style_in = '0;
    colour_in = '0;
`ifdef SPRITE_RENDERER_MIRROR_EN
    mirror_in = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    do_req(30, 108, 0, 7, 0, 0);
    do_req(31, 108, 0, 7, 0, 0);
    do_req(157, 118, 1, 2, 0, 0);
    do_req(156, 118, 1, 2, 0, 0);
    do_req(40, 50, 2, 3, 0, 1);
    for (int i = 0; i < 3; i++) begin
      check("no_queued_start", int'(busy), 0);
      @(negedge clk);
    end
    do_req(40, 50, 2, 3, 0, 1);
    do_req(41, 51, 3, 1, 1, 0);
    x_in = 8'd20;
    y_in = 7'd20;
    style_in = 2'd0;
    colour_in = 3'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W * H + 20) @(negedge clk);
    check("pre_reset_plot", int'(plot), 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    pv = 0;
    @(negedge clk);
    do_req(10, 10, 0, 6, 0, 0);
    for (int i = 0; i < 25; i++)
      do_req($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 3),
             $urandom_range(0, 7), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
